crypt_job_sequencer: RTL and testbench
======================================

Name: crypt_job_sequencer

Overview:
- Upstream feeder for the 16-bit encryption co-processor.
- Accepts (data, mode) jobs over a valid/ready stream and buffers them in a small FIFO.
- Presents one job at a time to the co-processor: a 1-cycle co-processor reset, then data/mode held stable for a fixed settle window.
- Captures the co-processor result and returns it, tagged with its mode, over a valid/ready output stream.

Parameters:
- WIDTH, 16, data width of jobs and results.
- DEPTH, 4, input FIFO entries; power of two, ≥2.
- HOLD_CYCLES, 10, cycles the job is held after cp_rst deasserts before the result is sampled; ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- in_valid  in  1  job offered.
- in_ready  out  1  FIFO can accept (not full).
- in_data  in  WIDTH  job plaintext/ciphertext.
- in_mode  in  1  0 = encrypt, 1 = decrypt.
- cp_rst  out  1  active-high reset pulse to co-processor.
- cp_data  out  WIDTH  data driven to co-processor data_in.
- cp_mode  out  1  mode driven to co-processor.
- cp_result  in  WIDTH  co-processor data_out.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_data  out  WIDTH  captured result.
- out_mode  out  1  mode of the job that produced out_data.
- busy  out  1  FSM not in IDLE.
- jobs_done  out  8  completed-job count; wraps 255→0.

Behaviour:
- Reset (async assert, sync release):
  - FIFO empty, in_ready=1, FSM=IDLE.
  - cp_rst=0, cp_data=0, cp_mode=0.
  - out_valid=0, out_data=0, out_mode=0, busy=0, jobs_done=0.
- FIFO:
  - Push when in_valid & in_ready.
  - Pop only on the IDLE→LOAD transition.
  - in_ready = !full, registered-count based; a same-cycle pop does not raise in_ready until the next cycle.
  - Push and pop in the same cycle: count unchanged, both take effect.
  - Pointers wrap modulo DEPTH.
  - Push while full is blocked by in_ready=0; no overwrite.
- FSM states: IDLE, LOAD, HOLD, CAPTURE, OUTPUT.
  - IDLE: if FIFO non-empty → LOAD; pop head into cp_data/cp_mode registers.
  - LOAD: exactly 1 cycle with cp_rst=1; cp_data/cp_mode stable. → HOLD with hold counter = HOLD_CYCLES-1.
  - HOLD: cp_rst=0, cp_data/cp_mode stable. Decrement counter; at 0 → CAPTURE.
  - CAPTURE: 1 cycle; out_data←cp_result, out_mode←cp_mode, out_valid←1, jobs_done+1. → OUTPUT.
  - OUTPUT: hold out_data/out_mode/out_valid stable until out_valid & out_ready. On that handshake edge out_valid←0 → IDLE.
- Latency:
  - IDLE-pop edge to cp_rst high: next cycle.
  - cp_rst high to out_valid high: 1 (LOAD) + HOLD_CYCLES (HOLD) + 1 (CAPTURE).
  - With out_ready held 1: job throughput = HOLD_CYCLES+4 cycles.
- Ordering: strictly FIFO; no job overlap. The co-processor holds exactly one job per cp_rst pulse.
- cp_data/cp_mode keep the last job's value while in IDLE; they never change outside the IDLE→LOAD edge.
- busy=1 in LOAD/HOLD/CAPTURE/OUTPUT.
- in_valid/in_data may change freely while in_ready=0; no sampling occurs.
- Reset asserted mid-job: job abandoned, FIFO flushed, all outputs return to reset values immediately; no partial result is emitted.

Test Plan:
- Bench model for the co-processor: cp_result = ~cp_data, 1-cycle registered, reset by cp_rst.
- Single job: push 16'hA5C3 mode 0, out_ready=1 → cp_rst high exactly 1 cycle with cp_data=16'hA5C3, cp_mode=0; out_valid rises HOLD_CYCLES+2 cycles after cp_rst rises; out_data=16'h5A3C, out_mode=0; jobs_done=1.
- Back-pressure and full:
  - Stimulus: out_ready=0, push 16'h0001 through 16'h0005 with mode alternating 0,1,0,1,0.
  - Job 1 is popped into the FSM and ends in OUTPUT; jobs 2–5 fill the FIFO; in_ready=0 after the 5th accept; a 6th offer is not accepted.
  - Release out_ready: results ~0001..~0005 appear in order with modes 0,1,0,1,0.
- Simultaneous push/pop: FIFO holds 1 entry; push in the same cycle IDLE pops → count remains 1, the pushed job is processed next, nothing lost.
- Output stall: hold out_ready=0 for 20 cycles in OUTPUT → out_data/out_mode/out_valid unchanged, cp_rst stays 0, no new pop.
- Reset mid-HOLD: 3 jobs queued, assert reset during HOLD → all outputs 0 and in_ready=1 in the same cycle; after release, no out_valid without new pushes; jobs_done=0.
- Counter wrap: run 256 jobs → jobs_done goes 255→0.

Source files
------------

// File: rtl/crypt_job_sequencer.sv
// Job feeder for the 16-bit encryption co-processor: buffers (data, mode) jobs,
// runs each through a reset/settle/capture sequence and streams results back.
module crypt_job_sequencer #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned HOLD_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             cp_rst,
    output logic [WIDTH-1:0] cp_data,
    output logic             cp_mode,
    input  logic [WIDTH-1:0] cp_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_mode,
    output logic             busy,
    output logic [7:0]       jobs_done
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HOLD,
        S_CAPTURE,
        S_OUTPUT
    } state_t;

    state_t           state_q, state_d;
    logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
    logic [WIDTH-1:0] fifo_data_q [DEPTH];
    logic [WIDTH-1:0] fifo_data_d [DEPTH];
    logic [DEPTH-1:0] fifo_mode_q, fifo_mode_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             in_ready_q, in_ready_d;
    logic             cp_rst_q, cp_rst_d;
    logic [WIDTH-1:0] cp_data_q, cp_data_d;
    logic             cp_mode_q, cp_mode_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_mode_q, out_mode_d;
    logic             busy_q, busy_d;
    logic [7:0]       jobs_done_q, jobs_done_d;
    logic             push;
    logic             pop;

    // Next-state, FIFO bookkeeping and registered-output computation
    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        fifo_data_d = fifo_data_q;
        fifo_mode_d = fifo_mode_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        cp_data_d   = cp_data_q;
        cp_mode_d   = cp_mode_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_mode_d  = out_mode_q;
        jobs_done_d = jobs_done_q;
        push        = in_valid && in_ready_q;
        pop         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop       = 1'b1;
                    state_d   = S_LOAD;
                    cp_data_d = fifo_data_q[rd_ptr_q];
                    cp_mode_d = fifo_mode_q[rd_ptr_q];
                end
            end
            S_LOAD: begin
                state_d    = S_HOLD;
                hold_cnt_d = HW'(HOLD_CYCLES - 1);
            end
            S_HOLD: begin
                if (hold_cnt_q == '0) begin
                    state_d = S_CAPTURE;
                end else begin
                    hold_cnt_d = hold_cnt_q - HW'(1);
                end
            end
            S_CAPTURE: begin
                out_data_d  = cp_result;
                out_mode_d  = cp_mode_q;
                out_valid_d = 1'b1;
                jobs_done_d = jobs_done_q + 8'd1;
                state_d     = S_OUTPUT;
            end
            S_OUTPUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (push) begin
            fifo_data_d[wr_ptr_q] = in_data;
            fifo_mode_d[wr_ptr_q] = in_mode;
            wr_ptr_d              = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // in_ready tracks the post-update occupancy, so it is visible one cycle later
        in_ready_d = (count_d != CW'(DEPTH));
        cp_rst_d   = (state_d == S_LOAD);
        busy_d     = (state_d != S_IDLE);
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            hold_cnt_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_data_q[i] <= '0;
            end
            fifo_mode_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            cp_rst_q    <= 1'b0;
            cp_data_q   <= '0;
            cp_mode_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_mode_q  <= 1'b0;
            busy_q      <= 1'b0;
            jobs_done_q <= '0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            fifo_data_q <= fifo_data_d;
            fifo_mode_q <= fifo_mode_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            cp_rst_q    <= cp_rst_d;
            cp_data_q   <= cp_data_d;
            cp_mode_q   <= cp_mode_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_mode_q  <= out_mode_d;
            busy_q      <= busy_d;
            jobs_done_q <= jobs_done_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign cp_rst    = cp_rst_q;
    assign cp_data   = cp_data_q;
    assign cp_mode   = cp_mode_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_mode  = out_mode_q;
    assign busy      = busy_q;
    assign jobs_done = jobs_done_q;

endmodule

// File: tb/tb_crypt_job_sequencer.sv
// Directed bench for crypt_job_sequencer with an inverting co-processor model
// and a result scoreboard fed from accepted input handshakes.
module tb_crypt_job_sequencer;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned HOLD  = 10;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_mode;
    logic             cp_rst;
    logic [WIDTH-1:0] cp_data;
    logic             cp_mode;
    logic [WIDTH-1:0] cp_result = '0;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_mode;
    logic             busy;
    logic [7:0]       jobs_done;

    int checks = 0;
    int errors = 0;
    logic [16:0] sb [$];
    logic [16:0] exp_e;

    crypt_job_sequencer #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_mode  (in_mode),
        .cp_rst   (cp_rst),
        .cp_data  (cp_data),
        .cp_mode  (cp_mode),
        .cp_result(cp_result),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_mode (out_mode),
        .busy     (busy),
        .jobs_done(jobs_done)
    );

    always #5 clk = ~clk;

    // Co-processor model: registered inversion, cleared by its reset pulse
    always @(posedge clk) cp_result <= cp_rst ? '0 : ~cp_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one job and hold it until the DUT accepts it
    task automatic push_job(input logic [15:0] d, input logic m);
        logic acc;
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        do begin
            acc = in_ready;
            step();
            n++;
        end while (!acc && n < 2000);
        in_valid = 1'b0;
        if (!acc) chk("push_timeout", 32'(acc), 32'd1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 6000) begin
            step();
            n++;
        end
        chk("drain_timeout", 32'(sb.size() == 0 && !busy), 32'd1);
    endtask

    task automatic wait_out_valid();
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            step();
            n++;
        end
        chk("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    // Scoreboard: inputs are stable from posedge+1, so the mid-cycle view predicts each handshake
    always @(negedge clk) begin
        if (reset) begin
            if (in_valid && in_ready) sb.push_back({in_mode, ~in_data});
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 32'(sb.size()), 32'd1);
                end else begin
                    exp_e = sb.pop_front();
                    chk("out_data", 32'(out_data), 32'(exp_e[15:0]));
                    chk("out_mode", 32'(out_mode), 32'(exp_e[16]));
                end
            end
        end
    end

    initial begin
        int n;
        logic ok;
        logic [15:0] od;
        logic om;

        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_cp_rst", 32'(cp_rst), 32'd0);
        chk("rst_cp_data", 32'(cp_data), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_jobs_done", 32'(jobs_done), 32'd0);
        reset = 1'b1;
        step();

        // Single job: reset pulse width, latency and result
        out_ready = 1'b1;
        push_job(16'hA5C3, 1'b0);
        n = 0;
        while (!cp_rst && n < 10) begin
            step();
            n++;
        end
        chk("single_cp_rst_rise", 32'(cp_rst), 32'd1);
        chk("single_cp_data", 32'(cp_data), 32'hA5C3);
        chk("single_cp_mode", 32'(cp_mode), 32'd0);
        step();
        chk("single_cp_rst_width", 32'(cp_rst), 32'd0);
        n = 1;
        while (!out_valid && n < 50) begin
            step();
            n++;
        end
        chk("single_latency", 32'(n), 32'(HOLD + 2));
        chk("single_out_data", 32'(out_data), 32'h5A3C);
        chk("single_out_mode", 32'(out_mode), 32'd0);
        wait_drain();
        chk("single_jobs_done", 32'(jobs_done), 32'd1);

        // Back-pressure: one job parked in OUTPUT, four more fill the FIFO
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) push_job(16'(i), (i % 2) == 0);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_data  = 16'h0006;
        in_mode  = 1'b1;
        step();
        step();
        step();
        chk("full_sixth_blocked", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        wait_out_valid();
        chk("stall_out_data", 32'(out_data), 32'hFFFE);

        // Output stall: nothing may move for 20 cycles
        od = out_data;
        om = out_mode;
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (out_data !== od || out_mode !== om || out_valid !== 1'b1 ||
                cp_rst !== 1'b0 || in_ready !== 1'b0) ok = 1'b0;
        end
        chk("stall_stable", 32'(ok), 32'd1);
        out_ready = 1'b1;
        wait_drain();
        chk("bp_jobs_done", 32'(jobs_done), 32'd6);

        // Simultaneous push and pop on the IDLE->LOAD edge
        out_ready = 1'b0;
        push_job(16'h1234, 1'b1);
        push_job(16'hBEEF, 1'b0);
        wait_out_valid();
        out_ready = 1'b1;
        step();
        chk("pp_idle", 32'(busy), 32'd0);
        push_job(16'h0F0F, 1'b1);
        chk("pp_cp_rst", 32'(cp_rst), 32'd1);
        chk("pp_cp_data", 32'(cp_data), 32'hBEEF);
        chk("pp_in_ready", 32'(in_ready), 32'd1);
        wait_drain();
        chk("pp_jobs_done", 32'(jobs_done), 32'd9);

        // Reset during HOLD with jobs still queued
        push_job(16'h1111, 1'b0);
        push_job(16'h2222, 1'b1);
        push_job(16'h3333, 1'b0);
        chk("rh_busy", 32'(busy), 32'd1);
        step();
        #2 reset = 1'b0;
        #1;
        chk("rh_busy_clr", 32'(busy), 32'd0);
        chk("rh_in_ready", 32'(in_ready), 32'd1);
        chk("rh_cp_data", 32'(cp_data), 32'd0);
        chk("rh_jobs_done", 32'(jobs_done), 32'd0);
        chk("rh_outs", 32'({cp_rst, cp_mode, out_valid, out_mode, out_data}), 32'd0);
        sb.delete();
        step();
        reset = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (out_valid !== 1'b0 || busy !== 1'b0) ok = 1'b0;
        end
        chk("rh_quiet", 32'(ok), 32'd1);
        chk("rh_jobs_after", 32'(jobs_done), 32'd0);

        // Counter wrap: 255 jobs, then one more rolls jobs_done to 0
        for (int i = 0; i < 255; i++) push_job(16'($urandom), 1'($urandom));
        wait_drain();
        chk("wrap_255", 32'(jobs_done), 32'd255);
        push_job(16'hC0DE, 1'b1);
        wait_drain();
        chk("wrap_0", 32'(jobs_done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
